// File: rtl/hkr_bus_pkg.sv
// Shared types and defaults for the hkr_mips instruction-bus bridge.
package hkr_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DATA,
    DONE
  } ibus_bridge_state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/ibus_avalon_bridge_if.sv
// CPU instruction-bus and Avalon-MM signals seen by the bridge.
// master: the bridge's view; slave: the CPU plus Avalon slave around it.
interface ibus_avalon_bridge_if;

  logic [31:0] ibus_addr;
  logic [3:0]  ibus_byte_en;
  logic        ibus_read;
  logic        ibus_write;
  logic [31:0] ibus_write_data;
  logic [31:0] ibus_read_data;
  logic        ibus_stall;
  logic        bus_error;

  logic [31:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    input  ibus_addr, ibus_byte_en, ibus_read, ibus_write, ibus_write_data,
    output ibus_read_data, ibus_stall, bus_error,
    output avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    output ibus_addr, ibus_byte_en, ibus_read, ibus_write, ibus_write_data,
    input  ibus_read_data, ibus_stall, bus_error,
    input  avm_address, avm_byteenable, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );

endinterface

// File: rtl/bridge_timeout_counter.sv
// Counts cycles of an outstanding transaction; expire is high in the
// last allowed cycle so the FSM completes exactly TIMEOUT_CYCLES after issue.
module bridge_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expire = enable && (count_reg == LAST);

endmodule

// File: rtl/ibus_avalon_bridge.sv
// Converts the CPU's held request/stall protocol into one outstanding
// Avalon-MM pipelined transaction, with timeout-forced completion.
module ibus_avalon_bridge
  import hkr_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = DEFAULT_ERR_DATA
) (
  input logic                  clk,
  input logic                  rst_n,
  ibus_avalon_bridge_if.master bus
);

  ibus_bridge_state_t state_reg;
  logic [31:0] cmd_addr_reg;
  logic [3:0]  byte_en_reg;
  logic [31:0] wdata_reg;
  logic        avm_read_reg;
  logic        avm_write_reg;
  logic [31:0] read_data_reg;
  logic        bus_error_reg;
  logic        orphan_reg;

  logic cpu_req;
  logic in_flight;
  logic orphan_now;
  logic expire;
  ibus_bridge_state_t finish_state;

  assign cpu_req      = bus.ibus_read | bus.ibus_write;
  assign in_flight    = (state_reg == ISSUE) || (state_reg == WAIT_DATA);
  // An abandoned request still has to finish on Avalon, but must not touch the CPU.
  assign orphan_now   = orphan_reg |
                        (in_flight & (!cpu_req | (bus.ibus_addr != cmd_addr_reg)));
  assign finish_state = orphan_now ? IDLE : DONE;

  bridge_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_reg == IDLE),
    .enable(in_flight),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_addr_reg  <= '0;
      byte_en_reg   <= '0;
      wdata_reg     <= '0;
      avm_read_reg  <= 1'b0;
      avm_write_reg <= 1'b0;
      read_data_reg <= '0;
      bus_error_reg <= 1'b0;
      orphan_reg    <= 1'b0;
    end else begin
      bus_error_reg <= 1'b0;
      orphan_reg    <= orphan_now;
      case (state_reg)
        IDLE: begin
          orphan_reg <= 1'b0;
          if (cpu_req) begin
            cmd_addr_reg  <= bus.ibus_addr;
            byte_en_reg   <= bus.ibus_byte_en;
            wdata_reg     <= bus.ibus_write_data;
            avm_read_reg  <= bus.ibus_read;
            avm_write_reg <= !bus.ibus_read;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!bus.avm_waitrequest) begin
            avm_read_reg  <= 1'b0;
            avm_write_reg <= 1'b0;
            if (avm_write_reg) begin
              state_reg  <= finish_state;
              orphan_reg <= 1'b0;
            end else if (bus.avm_readdatavalid) begin
              if (!orphan_now) read_data_reg <= bus.avm_readdata;
              state_reg  <= finish_state;
              orphan_reg <= 1'b0;
            end else begin
              state_reg <= WAIT_DATA;
            end
          end else if (expire) begin
            avm_read_reg  <= 1'b0;
            avm_write_reg <= 1'b0;
            bus_error_reg <= 1'b1;
            if (avm_read_reg && !orphan_now) read_data_reg <= ERR_DATA;
            state_reg  <= finish_state;
            orphan_reg <= 1'b0;
          end
        end
        WAIT_DATA: begin
          if (bus.avm_readdatavalid) begin
            if (!orphan_now) read_data_reg <= bus.avm_readdata;
            state_reg  <= finish_state;
            orphan_reg <= 1'b0;
          end else if (expire) begin
            bus_error_reg <= 1'b1;
            if (!orphan_now) read_data_reg <= ERR_DATA;
            state_reg  <= finish_state;
            orphan_reg <= 1'b0;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Stall is deliberately independent of avm_* inputs.
  assign bus.ibus_stall     = cpu_req & (state_reg != DONE);
  assign bus.ibus_read_data = read_data_reg;
  assign bus.bus_error      = bus_error_reg;
  assign bus.avm_address    = {cmd_addr_reg[31:2], 2'b00};
  assign bus.avm_byteenable = byte_en_reg;
  assign bus.avm_writedata  = wdata_reg;
  assign bus.avm_read       = avm_read_reg;
  assign bus.avm_write      = avm_write_reg;

endmodule

// File: tb/tb_ibus_avalon_bridge.sv
// Directed bench for ibus_avalon_bridge with hand-computed expectations.
module tb_ibus_avalon_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  ibus_avalon_bridge_if bus ();

  ibus_avalon_bridge #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    bus.ibus_read       = rd;
    bus.ibus_write      = wr;
    bus.ibus_addr       = addr;
    bus.ibus_byte_en    = be;
    bus.ibus_write_data = wd;
  endtask

  task automatic slave(input logic wait_req, input logic rdv, input logic [31:0] rdata);
    bus.avm_waitrequest   = wait_req;
    bus.avm_readdatavalid = rdv;
    bus.avm_readdata      = rdata;
  endtask

  initial begin
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    slave(1'b0, 1'b0, 32'h0);
    #1;
    check_vec("rst_avm_read", bus.avm_read, 1'b0);
    check_vec("rst_avm_addr", bus.avm_address, 32'h0);
    check_vec("rst_rdata", bus.ibus_read_data, 32'h0);
    check_vec("rst_bus_error", bus.bus_error, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Zero-wait read, data one cycle after accept
    $display("txn: read 80000000 zero-wait");
    cpu_req(1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    #1 check_vec("r1_idle_stall", bus.ibus_stall, 1'b1);
    tick();
    check_vec("r1_avm_read", bus.avm_read, 1'b1);
    check_vec("r1_avm_addr", bus.avm_address, 32'h8000_0000);
    check_vec("r1_issue_stall", bus.ibus_stall, 1'b1);
    tick();
    slave(1'b0, 1'b1, 32'h2402_0001);
    #1 check_vec("r1_read_one_cycle", bus.avm_read, 1'b0);
    check_vec("r1_wait_stall", bus.ibus_stall, 1'b1);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("r1_done_stall", bus.ibus_stall, 1'b0);
    check_vec("r1_rdata", bus.ibus_read_data, 32'h2402_0001);
    check_vec("r1_no_error", bus.bus_error, 1'b0);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // Read with waitrequest held for 4 cycles
    $display("txn: read 80000010 with 4 wait cycles");
    cpu_req(1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("r2_hold_read", bus.avm_read, 1'b1);
      check_vec("r2_hold_addr", bus.avm_address, 32'h8000_0010);
      check_vec("r2_hold_stall", bus.ibus_stall, 1'b1);
    end
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("r2_accept_read", bus.avm_read, 1'b1);
    tick();
    slave(1'b0, 1'b1, 32'h1234_5678);
    #1 check_vec("r2_wait_stall", bus.ibus_stall, 1'b1);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("r2_done_stall", bus.ibus_stall, 1'b0);
    check_vec("r2_rdata", bus.ibus_read_data, 32'h1234_5678);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // Byte write to an unaligned address
    $display("txn: write 80000103 be=1000 data=ab000000");
    cpu_req(1'b0, 1'b1, 32'h8000_0103, 4'b1000, 32'hAB00_0000);
    tick();
    check_vec("w_avm_write", bus.avm_write, 1'b1);
    check_vec("w_avm_read", bus.avm_read, 1'b0);
    check_vec("w_avm_addr", bus.avm_address, 32'h8000_0100);
    check_vec("w_avm_be", bus.avm_byteenable, 4'b1000);
    check_vec("w_avm_wdata", bus.avm_writedata, 32'hAB00_0000);
    check_vec("w_issue_stall", bus.ibus_stall, 1'b1);
    tick();
    check_vec("w_write_one_cycle", bus.avm_write, 1'b0);
    check_vec("w_done_stall", bus.ibus_stall, 1'b0);
    check_vec("w_rdata_kept", bus.ibus_read_data, 32'h1234_5678);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // CPU abandons a read in WAIT_DATA; late data must be dropped
    $display("txn: orphaned read 80000020");
    cpu_req(1'b1, 1'b0, 32'h8000_0020, 4'hF, 32'h0);
    tick();
    tick();
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    #1 check_vec("o_wait_read_low", bus.avm_read, 1'b0);
    tick();
    slave(1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    cpu_req(1'b1, 1'b0, 32'h8000_0030, 4'hF, 32'h0);
    #1 check_vec("o_no_release", bus.ibus_stall, 1'b1);
    check_vec("o_rdata_kept", bus.ibus_read_data, 32'h1234_5678);
    tick();
    check_vec("o_next_read", bus.avm_read, 1'b1);
    check_vec("o_next_addr", bus.avm_address, 32'h8000_0030);
    tick();
    slave(1'b0, 1'b1, 32'h0BAD_F00D);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("o_next_stall", bus.ibus_stall, 1'b0);
    check_vec("o_next_rdata", bus.ibus_read_data, 32'h0BAD_F00D);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    // Slave never accepts: forced error completion after 8 cycles
    $display("txn: timeout read 80000040");
    cpu_req(1'b1, 1'b0, 32'h8000_0040, 4'hF, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_vec("t_hold_read", bus.avm_read, 1'b1);
      check_vec("t_hold_err", bus.bus_error, 1'b0);
      check_vec("t_hold_stall", bus.ibus_stall, 1'b1);
    end
    tick();
    check_vec("t_read_dropped", bus.avm_read, 1'b0);
    check_vec("t_bus_error", bus.bus_error, 1'b1);
    check_vec("t_stall_low", bus.ibus_stall, 1'b0);
    check_vec("t_err_data", bus.ibus_read_data, 32'hFFFF_FFFF);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    slave(1'b0, 1'b0, 32'h0);
    tick();
    check_vec("t_error_pulse", bus.bus_error, 1'b0);
    slave(1'b0, 1'b1, 32'h5555_5555);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("t_late_rdv_ignored", bus.ibus_read_data, 32'hFFFF_FFFF);
    tick();

    // Async reset while a read is outstanding
    $display("txn: reset during read 80000050");
    cpu_req(1'b1, 1'b0, 32'h8000_0050, 4'hF, 32'h0);
    tick();
    tick();
    rst_n = 1'b0;
    #1 check_vec("x_rst_addr", bus.avm_address, 32'h0);
    check_vec("x_rst_be", bus.avm_byteenable, 4'h0);
    check_vec("x_rst_rdata", bus.ibus_read_data, 32'h0);
    check_vec("x_rst_read", bus.avm_read, 1'b0);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    slave(1'b0, 1'b1, 32'h7777_7777);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("x_stale_rdv", bus.ibus_read_data, 32'h0);
    cpu_req(1'b1, 1'b0, 32'h8000_0060, 4'hF, 32'h0);
    tick();
    check_vec("x_next_addr", bus.avm_address, 32'h8000_0060);
    tick();
    slave(1'b0, 1'b1, 32'h3C1C_8000);
    tick();
    slave(1'b0, 1'b0, 32'h0);
    #1 check_vec("x_next_stall", bus.ibus_stall, 1'b0);
    check_vec("x_next_rdata", bus.ibus_read_data, 32'h3C1C_8000);
    cpu_req(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
